dkong3_obj_dma: RTL

//  Sprite DMA sequencer that fills the object RAM (6P/6R) once per frame. On the start of vertical

---
 rtl/dkong3_obj_dma.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/dkong3_obj_dma.sv
// Sprite DMA sequencer: on each vertical-blank start it takes the CPU bus and copies the sprite
// work RAM into one half of object RAM through the object block's DMA write port.
module dkong3_obj_dma #(
  parameter int unsigned XFER_LEN = 384,
  parameter logic [15:0] SRC_BASE = 16'h7000,
  parameter int unsigned RD_WAIT  = 2
) (
  input  logic        I_CLK_24M,
  input  logic        I_RESETn,
  input  logic        I_CE,
  input  logic        I_VBLKn,
  input  logic        I_DMA_EN,
  input  logic        I_BANK,
  input  logic        I_BUSAKn,
  input  logic [7:0]  I_SRC_D,
  output logic        O_BUSRQn,
  output logic [15:0] O_SRC_A,
  output logic        O_SRC_RDn,
  output logic [9:0]  O_OBJ_DMA_A,
  output logic [7:0]  O_OBJ_DMA_D,
  output logic        O_OBJ_DMA_CE,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_SKIP
);

  localparam logic [8:0] LastIdx  = 9'(XFER_LEN - 1);
  localparam logic [2:0] LastWait = 3'(RD_WAIT - 1);

  typedef enum logic [2:0] {StIdle, StReq, StRd, StWr, StRel} state_e;

  state_e     state_q, state_d;
  logic       vblk_q;
  logic       pend_q, pend_d;
  logic       bank_q, bank_d;
  logic [8:0] index_q, index_d;
  logic [2:0] wait_q, wait_d;
  logic [9:0] obj_a_q, obj_a_d;
  logic [7:0] obj_d_q, obj_d_d;
  logic       wr_first_q, wr_first_d;
  logic       trig_edge;
  logic       grant_lost;

  // vblk_q resets low so a vblank already in progress at reset release is not taken as an edge.
  assign trig_edge    = vblk_q & ~I_VBLKn & I_DMA_EN;
  assign grant_lost   = ((state_q == StRd) || (state_q == StWr)) && I_BUSAKn;
  assign O_SRC_A      = SRC_BASE + {7'd0, index_q};
  assign O_OBJ_DMA_A  = obj_a_q;
  assign O_OBJ_DMA_D  = obj_d_q;
  assign O_BUSY       = (state_q != StIdle);

  // State and datapath registers.
  always_ff @(posedge I_CLK_24M or negedge I_RESETn) begin
    if (!I_RESETn) begin
      state_q    <= StIdle;
      vblk_q     <= 1'b0;
      pend_q     <= 1'b0;
      bank_q     <= 1'b0;
      index_q    <= 9'd0;
      wait_q     <= 3'd0;
      obj_a_q    <= 10'd0;
      obj_d_q    <= 8'd0;
      wr_first_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vblk_q     <= I_VBLKn;
      pend_q     <= pend_d;
      bank_q     <= bank_d;
      index_q    <= index_d;
      wait_q     <= wait_d;
      obj_a_q    <= obj_a_d;
      obj_d_q    <= obj_d_d;
      wr_first_q <= wr_first_d;
    end
  end

  // Next-state and bus/strobe outputs; grant loss overrides everything in RD/WR on any clock.
  always_comb begin
    state_d      = state_q;
    pend_d       = 1'b0;
    bank_d       = bank_q;
    index_d      = index_q;
    wait_d       = wait_q;
    obj_a_d      = obj_a_q;
    obj_d_d      = obj_d_q;
    wr_first_d   = 1'b0;
    O_BUSRQn     = 1'b1;
    O_SRC_RDn    = 1'b1;
    O_OBJ_DMA_CE = 1'b0;
    O_DONE       = 1'b0;
    O_SKIP       = 1'b0;
    case (state_q)
      StIdle: begin
        pend_d = pend_q | trig_edge;
        if (I_CE && (pend_q || trig_edge)) begin
          pend_d  = 1'b0;
          bank_d  = I_BANK;
          index_d = 9'd0;
          wait_d  = 3'd0;
          state_d = StReq;
        end
      end
      StReq: begin
        O_BUSRQn = 1'b0;
        if (I_CE) begin
          if (!I_BUSAKn) begin
            state_d = StRd;
          end else if (I_VBLKn) begin
            O_SKIP  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      StRd: begin
        if (grant_lost) begin
          O_SKIP  = 1'b1;
          state_d = StIdle;
        end else begin
          O_BUSRQn  = 1'b0;
          O_SRC_RDn = 1'b0;
          if (I_CE) begin
            if (wait_q == LastWait) begin
              wait_d     = 3'd0;
              obj_d_d    = I_SRC_D;
              obj_a_d    = {bank_q, index_q};
              wr_first_d = 1'b1;
              state_d    = StWr;
            end else begin
              wait_d = wait_q + 3'd1;
            end
          end
        end
      end
      StWr: begin
        if (grant_lost) begin
          O_SKIP  = 1'b1;
          state_d = StIdle;
        end else begin
          O_BUSRQn     = 1'b0;
          O_OBJ_DMA_CE = wr_first_q;
          if (I_CE) begin
            if (index_q == LastIdx) begin
              state_d = StRel;
            end else begin
              index_d = index_q + 9'd1;
              state_d = StRd;
            end
          end
        end
      end
      StRel: begin
        if (I_CE) begin
          O_DONE  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
